// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response each use their own valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory that answers one load/store at a time after LATENCY wait cycles.
// Misaligned or out-of-range addresses return an error and leave memory untouched.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rspValid_q;
  logic        rspErr_q;
  logic [31:0] rspRdata_q;
  logic [31:0] mem_q [2**ADDR_WIDTH];

  logic                  accWe_d;
  logic [31:0]           accAddr_d;
  logic [31:0]           accWdata_d;
  logic [3:0]            accBe_d;
  logic                  accErr_d;
  logic                  accFire_d;
  logic [ADDR_WIDTH-1:0] accIdx_d;
  logic [31:0]           rdWord_d;

  // With zero latency the access uses the live request; otherwise the captured copy.
  always_comb begin
    accWe_d    = we_q;
    accAddr_d  = addr_q;
    accWdata_d = wdata_q;
    accBe_d    = be_q;
    if (state_q == IDLE) begin
      accWe_d    = bus.req_we;
      accAddr_d  = bus.req_addr;
      accWdata_d = bus.req_wdata;
      accBe_d    = bus.req_be;
    end
    accErr_d  = (accAddr_d[1:0] != 2'b00) || (accAddr_d[31:ADDR_WIDTH+2] != '0);
    accIdx_d  = accAddr_d[ADDR_WIDTH+1:2];
    rdWord_d  = mem_q[accIdx_d];
    accFire_d = rst_n &&
                (((state_q == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                 ((state_q == BUSY) && (cnt_q == 4'd1)));
  end

  always_ff @(posedge clk) begin
    if (accFire_d && accWe_d && !accErr_d) begin
      for (int b = 0; b < 4; b++) begin
        if (accBe_d[b]) begin
          mem_q[accIdx_d][8*b +: 8] <= accWdata_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      if (accFire_d) begin
        rspValid_q <= 1'b1;
        rspErr_q   <= accErr_d;
        rspRdata_q <= (accWe_d || accErr_d) ? 32'h0 : rdWord_d;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=2, one with LATENCY=0.
// Expected responses are queued at issue time and popped by a monitor on each response handshake.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passCount = 0;
  int   totalCount = 0;
  exp_t sbq[$];
  exp_t sbq0[$];

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  // A response handshake happens at the next rising edge; compare it against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      totalCount++;
      if (sbq.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: got response rdata=%h err=%b, required none", bus.rsp_rdata, bus.rsp_err);
      end else begin
        passCount++;
        e = sbq.pop_front();
        totalCount++;
        if (bus.rsp_rdata !== e.rdata) $display("[TB] FAIL sb_rdata: got %h, required %h", bus.rsp_rdata, e.rdata);
        else passCount++;
        totalCount++;
        if (bus.rsp_err !== e.err) $display("[TB] FAIL sb_err: got %b, required %b", bus.rsp_err, e.err);
        else passCount++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus0.rsp_valid && bus0.rsp_ready) begin
      totalCount++;
      if (sbq0.size() == 0) begin
        $display("[TB] FAIL sb0_unexpected: got response rdata=%h err=%b, required none", bus0.rsp_rdata, bus0.rsp_err);
      end else begin
        passCount++;
        e = sbq0.pop_front();
        totalCount++;
        if (bus0.rsp_rdata !== e.rdata) $display("[TB] FAIL sb0_rdata: got %h, required %h", bus0.rsp_rdata, e.rdata);
        else passCount++;
        totalCount++;
        if (bus0.rsp_err !== e.err) $display("[TB] FAIL sb0_err: got %b, required %b", bus0.rsp_err, e.err);
        else passCount++;
      end
    end
  end

  task automatic issueReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      totalCount++;
      $display("[TB] FAIL req_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int edges);
    edges = 0;
    while (!bus.rsp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.rsp_valid) edges = -1;
  endtask

  task automatic completeRsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic runOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                       output int edges);
    issueReq(we, addr, wdata, be);
    waitRsp(edges);
    completeRsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid);
    else passCount++;
    totalCount++;
    if (bus.rsp_rdata !== 32'h0) $display("[TB] FAIL reset_rsp_rdata: got %h, required 0", bus.rsp_rdata);
    else passCount++;
    totalCount++;
    if (bus.rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b, required 0", bus.rsp_err);
    else passCount++;
    totalCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready_low: got %b, required 0", bus.req_ready);
    else passCount++;
    totalCount++;
    if (bus0.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid0: got %b, required 0", bus0.rsp_valid);
    else passCount++;
    rst_n = 1'b1;
    #1;
    totalCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready_high: got %b, required 1", bus.req_ready);
    else passCount++;
  endtask

  task automatic test_read_after_write();
    int ed;
    sbq.push_back(exp_t'{32'h0, 1'b0});
    issueReq(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    waitRsp(ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL raw_store_latency: got %0d edges, required 2", ed);
    else passCount++;
    completeRsp();
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL raw_rsp_drop: got %b, required 0", bus.rsp_valid);
    else passCount++;
    totalCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL raw_idle_ready: got %b, required 1", bus.req_ready);
    else passCount++;
    sbq.push_back(exp_t'{32'hDEADBEEF, 1'b0});
    runOp(1'b0, 32'h10, 32'h0, 4'h0, ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL raw_load_latency: got %0d edges, required 2", ed);
    else passCount++;
  endtask

  task automatic test_byte_enables();
    logic        opWe[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] opData[4] = '{32'h11223344, 32'hAABBCCDD, 32'h99999999, 32'h0};
    logic [3:0]  opBe[4]   = '{4'hF, 4'b0101, 4'b0000, 4'hF};
    logic [31:0] opRd[4]   = '{32'h0, 32'h0, 32'h0, 32'h11BB33DD};
    int ed;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(exp_t'{opRd[i], 1'b0});
      runOp(opWe[i], 32'h20, opData[i], opBe[i], ed);
      totalCount++;
      if (ed !== 2) $display("[TB] FAIL be_latency_%0d: got %0d edges, required 2", i, ed);
      else passCount++;
    end
  endtask

  task automatic test_backpressure();
    int ed;
    sbq.push_back(exp_t'{32'hDEADBEEF, 1'b0});
    issueReq(1'b0, 32'h10, 32'h0, 4'h0);
    waitRsp(ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL bp_latency: got %0d edges, required 2", ed);
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h77777777;
        bus.req_be    = 4'hF;
      end
      if (i == 3) bus.req_valid = 1'b0;
      totalCount++;
      if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL bp_valid_%0d: got %b, required 1", i, bus.rsp_valid);
      else passCount++;
      totalCount++;
      if (bus.rsp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL bp_rdata_%0d: got %h, required deadbeef", i, bus.rsp_rdata);
      else passCount++;
      totalCount++;
      if (bus.rsp_err !== 1'b0) $display("[TB] FAIL bp_err_%0d: got %b, required 0", i, bus.rsp_err);
      else passCount++;
      totalCount++;
      if (bus.req_ready !== 1'b0) $display("[TB] FAIL bp_req_ready_%0d: got %b, required 0", i, bus.req_ready);
      else passCount++;
      @(posedge clk); #1;
    end
    completeRsp();
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL bp_rsp_drop: got %b, required 0", bus.rsp_valid);
    else passCount++;
    totalCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL bp_idle_ready: got %b, required 1", bus.req_ready);
    else passCount++;
    repeat (4) @(posedge clk);
    #1;
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL bp_pulse_ignored: got rsp_valid %b, required 0", bus.rsp_valid);
    else passCount++;
  endtask

  task automatic test_misaligned();
    int ed;
    sbq.push_back(exp_t'{32'h0, 1'b1});
    runOp(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL misalign_latency: got %0d edges, required 2", ed);
    else passCount++;
    sbq.push_back(exp_t'{32'h11BB33DD, 1'b0});
    runOp(1'b0, 32'h20, 32'h0, 4'h0, ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL misalign_reload_latency: got %0d edges, required 2", ed);
    else passCount++;
  endtask

  task automatic test_out_of_range();
    logic        opWe[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] opAddr[6] = '{32'h0, 32'hFFC, 32'hFFC, 32'h1000, 32'h1000, 32'h0};
    logic [31:0] opData[6] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h12345678, 32'h0};
    logic [31:0] opRd[6]   = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    logic        opErr[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int ed;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(exp_t'{opRd[i], opErr[i]});
      runOp(opWe[i], opAddr[i], opData[i], 4'hF, ed);
      totalCount++;
      if (ed !== 2) $display("[TB] FAIL oor_latency_%0d: got %0d edges, required 2", i, ed);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid_op();
    int ed;
    sbq.push_back(exp_t'{32'h0, 1'b0});
    runOp(1'b1, 32'h30, 32'h0, 4'hF, ed);
    issueReq(1'b1, 32'h30, 32'h55555555, 4'hF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL midrst_rsp_valid: got %b, required 0", bus.rsp_valid);
    else passCount++;
    totalCount++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL midrst_req_ready_low: got %b, required 0", bus.req_ready);
    else passCount++;
    rst_n = 1'b1;
    #1;
    totalCount++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL midrst_req_ready_high: got %b, required 1", bus.req_ready);
    else passCount++;
    repeat (3) @(posedge clk);
    #1;
    totalCount++;
    if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL midrst_no_rsp: got %b, required 0", bus.rsp_valid);
    else passCount++;
    sbq.push_back(exp_t'{32'h0, 1'b0});
    runOp(1'b0, 32'h30, 32'h0, 4'h0, ed);
    totalCount++;
    if (ed !== 2) $display("[TB] FAIL midrst_load_latency: got %0d edges, required 2", ed);
    else passCount++;
  endtask

  task automatic test_zero_latency();
    logic        opWe[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] opAddr[5] = '{32'h4, 32'h8, 32'h4, 32'h8, 32'h4};
    logic [31:0] opData[5] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0};
    logic [31:0] opRd[5]   = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hA5A5A5A5};
    int idx = 0;
    int cyc = 0;
    int lastAcc = -1;
    logic acc;
    bus0.req_valid = 1'b1;
    bus0.req_we    = opWe[0];
    bus0.req_addr  = opAddr[0];
    bus0.req_wdata = opData[0];
    bus0.req_be    = 4'hF;
    while (idx < 5 && cyc < 60) begin
      @(negedge clk);
      acc = bus0.req_ready;
      if (acc) begin
        sbq0.push_back(exp_t'{opRd[idx], 1'b0});
        if (lastAcc >= 0) begin
          totalCount++;
          if (cyc - lastAcc !== 2) $display("[TB] FAIL zl_gap_%0d: got %0d cycles, required 2", idx, cyc - lastAcc);
          else passCount++;
        end
        lastAcc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        totalCount++;
        if (bus0.rsp_valid !== 1'b1) $display("[TB] FAIL zl_valid_%0d: got %b, required 1", idx, bus0.rsp_valid);
        else passCount++;
        idx++;
        if (idx < 5) begin
          bus0.req_we    = opWe[idx];
          bus0.req_addr  = opAddr[idx];
          bus0.req_wdata = opData[idx];
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
    end
    totalCount++;
    if (idx !== 5) $display("[TB] FAIL zl_timeout: got %0d accepted, required 5", idx);
    else passCount++;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_be     = 4'h0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'h0;
    bus0.req_wdata = 32'h0;
    bus0.req_be    = 4'h0;
    bus0.rsp_ready = 1'b1;
    test_reset();
    test_read_after_write();
    test_byte_enables();
    test_backpressure();
    test_misaligned();
    test_out_of_range();
    test_reset_mid_op();
    test_zero_latency();
    repeat (4) @(posedge clk);
    #1;
    totalCount++;
    if (sbq.size() !== 0) $display("[TB] FAIL sb_drain: got %0d pending, required 0", sbq.size());
    else passCount++;
    totalCount++;
    if (sbq0.size() !== 0) $display("[TB] FAIL sb0_drain: got %0d pending, required 0", sbq0.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
